puzzle_ctrl: RTL and testbench

PUZZLE_CTRL -- requirements
Module: puzzle_ctrl

---
 rtl/puzzle_pkg.sv | 41 ++++
 rtl/puzzle_ctrl_rise_edge.sv | 21 ++
 rtl/puzzle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_puzzle_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared definitions for the lamp puzzle controller: state encoding, LFSR
// constants and the default per-button toggle masks.
package puzzle_pkg;

  localparam logic [2:0] S_SELECT = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_PLAY   = 3'd2;
  localparam logic [2:0] S_WON    = 3'd3;
  localparam logic [2:0] S_LOST   = 3'd4;

  typedef enum logic [2:0] {
    ST_SELECT = S_SELECT,
    ST_INIT   = S_INIT,
    ST_PLAY   = S_PLAY,
    ST_WON    = S_WON,
    ST_LOST   = S_LOST
  } state_t;

  // Right-shift Galois toggle mask for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  localparam int MASK_MAX_W = 256;

  // Button i toggles lamps 3i..3i+2 (clipped to the board)
  function automatic logic [MASK_MAX_W-1:0] default_masks(input int nbtn, input int cells);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < nbtn; i++) begin
      for (int b = 0; b < cells; b++) begin
        if (b >= 3 * i && b < 3 * i + 3) m[i * cells + b] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/puzzle_ctrl_rise_edge.sv
// Registered rising-edge detector: a bit fires on the edge where it is
// sampled 1 after being 0 on the previous edge.
module rise_edge #(
  parameter int W = 1
) (
  input  logic         clk_d,
  input  logic         rst,
  input  logic [W-1:0] i_level,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) r_prev <= '0;
    else      r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/puzzle_ctrl.sv
// Lamp puzzle game controller. Define PUZZLE_UNDO_EN to build the move
// history and undo button; the default build has no history storage.
module puzzle_ctrl
  import puzzle_pkg::*;
#(
  parameter int CELLS      = 12,
  parameter int NBTN       = 4,
  parameter int STEP_W     = 14,
  parameter int MAX_STEPS  = 9999,
  parameter int UNDO_DEPTH = 8,
  parameter logic [NBTN*CELLS-1:0] MASKS = (NBTN*CELLS)'(default_masks(NBTN, CELLS))
) (
  input  logic              clk_d,
  input  logic              rst,
  input  logic              start_sw,
  input  logic              set_bt,
  input  logic [NBTN-1:0]   act_bt,
  input  logic              undo_bt,
  input  logic              random_sw,
  input  logic [CELLS-1:0]  board_in,
  output logic [CELLS-1:0]  board,
  output logic [2:0]        state,
  output logic [STEP_W-1:0] step_count,
  output logic              timer_en,
  output logic              win_flag,
  output logic              lose_flag
);

  localparam int IDX_W = (NBTN > 1) ? $clog2(NBTN) : 1;
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  state_t            r_state;
  logic [CELLS-1:0]  r_board;
  logic [STEP_W-1:0] r_step;
  logic              r_timer_en;
  logic              r_win;
  logic              r_lose;
  logic [31:0]       r_lfsr;

  logic              w_set_rise;
  logic [NBTN-1:0]   w_act_rise;
  logic [IDX_W-1:0]  w_act_idx;
  logic [CELLS-1:0]  w_mask [NBTN];
  logic [CELLS-1:0]  w_act_mask;
  logic [CELLS-1:0]  w_undo_mask;
  logic [CELLS-1:0]  w_lfsr_slice;
  logic [CELLS-1:0]  w_load_val;
  logic              w_play_ok;
  logic              w_push;
  logic              w_undo;

  rise_edge #(.W(1)) u_set_edge (
    .clk_d  (clk_d),
    .rst    (rst),
    .i_level(set_bt),
    .o_rise (w_set_rise)
  );

  rise_edge #(.W(NBTN)) u_act_edge (
    .clk_d  (clk_d),
    .rst    (rst),
    .i_level(act_bt),
    .o_rise (w_act_rise)
  );

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_mask
    assign w_mask[gi] = MASKS[gi*CELLS +: CELLS];
  end

  always_comb begin
    w_act_idx = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (w_act_rise[i]) w_act_idx = IDX_W'(i);
    end
  end

  assign w_act_mask   = w_mask[w_act_idx];
  assign w_lfsr_slice = r_lfsr[CELLS-1:0];
  assign w_load_val   = !random_sw ? board_in :
                        (w_lfsr_slice == '0) ? CELLS'(1) : w_lfsr_slice;

  // A move may only land when PLAY is not about to end this edge
  assign w_play_ok = (r_state == ST_PLAY) && start_sw &&
                     (r_board != '0) && (r_step != STEP_MAX);
  assign w_push    = w_play_ok && !w_undo && $onehot(w_act_rise);

`ifdef PUZZLE_UNDO_EN
  localparam int PTR_W = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int CNT_W = $clog2(UNDO_DEPTH + 1);

  logic             w_undo_rise;
  logic [IDX_W-1:0] r_hist [UNDO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [PTR_W-1:0] w_wr_ptr_inc;
  logic [CNT_W-1:0] r_hist_cnt;

  rise_edge #(.W(1)) u_undo_edge (
    .clk_d  (clk_d),
    .rst    (rst),
    .i_level(undo_bt),
    .o_rise (w_undo_rise)
  );

  // Circular buffer: the newest entry sits just below the write pointer
  assign w_rd_ptr     = (r_wr_ptr == '0) ? PTR_W'(UNDO_DEPTH - 1) : r_wr_ptr - 1'b1;
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(UNDO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_undo       = w_play_ok && w_undo_rise && (r_hist_cnt != '0);
  assign w_undo_mask  = w_mask[r_hist[w_rd_ptr]];

  always_ff @(posedge clk_d) begin
    if (w_push) r_hist[r_wr_ptr] <= w_act_idx;
  end

  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_hist_cnt <= '0;
    end else if (r_state == ST_INIT && start_sw) begin
      r_hist_cnt <= '0;
    end else if (w_undo) begin
      r_wr_ptr   <= w_rd_ptr;
      r_hist_cnt <= r_hist_cnt - 1'b1;
    end else if (w_push) begin
      r_wr_ptr <= w_wr_ptr_inc;
      if (r_hist_cnt != CNT_W'(UNDO_DEPTH)) r_hist_cnt <= r_hist_cnt + 1'b1;
    end
  end
`else
  logic w_unused_undo;
  assign w_unused_undo = undo_bt;
  assign w_undo        = 1'b0;
  assign w_undo_mask   = '0;
`endif

  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_SELECT;
      r_board    <= '0;
      r_step     <= '0;
      r_timer_en <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
      if (r_state != ST_SELECT && !start_sw) begin
        r_state    <= ST_SELECT;
        r_board    <= '0;
        r_step     <= '0;
        r_timer_en <= 1'b0;
        r_win      <= 1'b0;
        r_lose     <= 1'b0;
      end else begin
        case (r_state)
          ST_SELECT: begin
            if (w_set_rise) begin
              r_board <= w_load_val;
              r_state <= ST_INIT;
            end
          end
          ST_INIT: begin
            if (w_set_rise) r_board <= w_load_val;
            r_step     <= '0;
            r_state    <= ST_PLAY;
            r_timer_en <= 1'b1;
          end
          ST_PLAY: begin
            if (r_board == '0) begin
              r_state    <= ST_WON;
              r_timer_en <= 1'b0;
              r_win      <= 1'b1;
            end else if (r_step == STEP_MAX) begin
              r_state    <= ST_LOST;
              r_timer_en <= 1'b0;
              r_lose     <= 1'b1;
            end else if (w_undo) begin
              r_board <= r_board ^ w_undo_mask;
              if (r_step != '0) r_step <= r_step - 1'b1;
            end else if (w_push) begin
              // w_play_ok already keeps the count below MAX_STEPS
              r_board <= r_board ^ w_act_mask;
              r_step  <= r_step + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign board      = r_board;
  assign state      = r_state;
  assign step_count = r_step;
  assign timer_en   = r_timer_en;
  assign win_flag   = r_win;
  assign lose_flag  = r_lose;

endmodule

// File: tb/tb_puzzle_ctrl.sv
// Self-checking bench for puzzle_ctrl: two instances (default limit and
// MAX_STEPS=3) checked every cycle against a queue-based game model.
module tb_puzzle_ctrl;
  import puzzle_pkg::*;

  localparam int CELLS  = 12;
  localparam int NBTN   = 4;
  localparam int STEP_W = 14;
`ifdef PUZZLE_UNDO_EN
  localparam bit UNDO_ON = 1'b1;
`else
  localparam bit UNDO_ON = 1'b0;
`endif

  logic              clk_d = 1'b0;
  logic              rst = 1'b0;
  logic              start_sw = 1'b0;
  logic              set_bt = 1'b0;
  logic              undo_bt = 1'b0;
  logic              random_sw = 1'b0;
  logic [NBTN-1:0]   act_bt = '0;
  logic [CELLS-1:0]  board_in = '0;

  logic [CELLS-1:0]  board_a, board_b;
  logic [2:0]        state_a, state_b;
  logic [STEP_W-1:0] step_a, step_b;
  logic              ten_a, ten_b, win_a, win_b, lose_a, lose_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_d = ~clk_d;

  puzzle_ctrl dut (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .set_bt(set_bt), .act_bt(act_bt),
    .undo_bt(undo_bt), .random_sw(random_sw), .board_in(board_in), .board(board_a),
    .state(state_a), .step_count(step_a), .timer_en(ten_a), .win_flag(win_a), .lose_flag(lose_a)
  );

  puzzle_ctrl #(.MAX_STEPS(3)) dut_lim (
    .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .set_bt(set_bt), .act_bt(act_bt),
    .undo_bt(undo_bt), .random_sw(random_sw), .board_in(board_in), .board(board_b),
    .state(state_b), .step_count(step_b), .timer_en(ten_b), .win_flag(win_b), .lose_flag(lose_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]       m_state [2];
  logic [CELLS-1:0] m_board [2];
  int               m_step  [2];
  int               m_hist  [2][$];
  int               m_max   [2] = '{9999, 3};
  logic [31:0]      m_lfsr;
  logic             p_set, p_undo;
  logic [NBTN-1:0]  p_act;

  function automatic logic [CELLS-1:0] mask_of(input int i);
    logic [31:0] m;
    m = 32'h7 << (3 * i);
    return m[CELLS-1:0];
  endfunction

  // x^32 + x^22 + x^2 + x + 1, shifting towards bit 0
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] taps;
    taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = S_SELECT;
      m_board[k] = '0;
      m_step[k]  = 0;
      m_hist[k].delete();
    end
    m_lfsr = 32'h1;
    p_set = 1'b0; p_undo = 1'b0; p_act = '0;
  endtask

  task automatic model_step();
    logic            set_e, undo_e;
    logic [NBTN-1:0] act_e;
    logic [CELLS-1:0] ld;
    int a_idx, j;
    set_e  = set_bt & ~p_set;
    undo_e = undo_bt & ~p_undo;
    act_e  = act_bt & ~p_act;
    a_idx = 0;
    for (int i = 0; i < NBTN; i++) if (act_e[i]) a_idx = i;
    ld = random_sw ? m_lfsr[CELLS-1:0] : board_in;
    if (random_sw && ld == '0) ld = 1;
    for (int k = 0; k < 2; k++) begin
      if (m_state[k] != S_SELECT && !start_sw) begin
        m_state[k] = S_SELECT; m_board[k] = '0; m_step[k] = 0;
      end else if (m_state[k] == S_SELECT) begin
        if (set_e) begin m_board[k] = ld; m_state[k] = S_INIT; end
      end else if (m_state[k] == S_INIT) begin
        if (set_e) m_board[k] = ld;
        m_step[k] = 0;
        m_hist[k].delete();
        m_state[k] = S_PLAY;
      end else if (m_state[k] == S_PLAY) begin
        if (m_board[k] == '0) m_state[k] = S_WON;
        else if (m_step[k] == m_max[k]) m_state[k] = S_LOST;
        else if (UNDO_ON && undo_e && m_hist[k].size() > 0) begin
          j = m_hist[k].pop_back();
          m_board[k] ^= mask_of(j);
          m_step[k]--;
        end else if ($countones(act_e) == 1) begin
          m_board[k] ^= mask_of(a_idx);
          m_step[k]++;
          m_hist[k].push_back(a_idx);
          if (m_hist[k].size() > 8) void'(m_hist[k].pop_front());
        end
      end
    end
    p_set = set_bt; p_undo = undo_bt; p_act = act_bt;
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  always @(posedge clk_d) if (rst) model_step();

  task automatic compare_all();
    check_eq("board_a", board_a, m_board[0]);
    check_eq("state_a", state_a, m_state[0]);
    check_eq("step_a", step_a, m_step[0]);
    check_eq("timer_a", ten_a, m_state[0] == S_PLAY);
    check_eq("win_a", win_a, m_state[0] == S_WON);
    check_eq("lose_a", lose_a, m_state[0] == S_LOST);
    check_eq("board_b", board_b, m_board[1]);
    check_eq("state_b", state_b, m_state[1]);
    check_eq("step_b", step_b, m_step[1]);
    check_eq("timer_b", ten_b, m_state[1] == S_PLAY);
    check_eq("win_b", win_b, m_state[1] == S_WON);
    check_eq("lose_b", lose_b, m_state[1] == S_LOST);
  endtask

  task automatic cycle();
    @(negedge clk_d);
    compare_all();
  endtask

  task automatic start_game(input logic [CELLS-1:0] val);
    start_sw = 1'b0; set_bt = 1'b0; act_bt = '0; undo_bt = 1'b0; random_sw = 1'b0;
    cycle();
    board_in = val; start_sw = 1'b1; set_bt = 1'b1;
    cycle();
    cycle();
    set_bt = 1'b0;
  endtask

  task automatic press(input int btn);
    act_bt = NBTN'(1 << btn);
    cycle();
  endtask

  task automatic release_all();
    act_bt = '0; undo_bt = 1'b0;
    cycle();
  endtask

  logic [CELLS-1:0] exp_rand;

  initial begin
    model_reset();
    @(negedge clk_d);
    @(negedge clk_d);
    check_eq("rst_board", board_a, 0);
    check_eq("rst_state", state_a, S_SELECT);
    check_eq("rst_step", step_a, 0);
    check_eq("rst_flags", {ten_a, win_a, lose_a}, 0);
    rst = 1'b1;
    cycle();

    // Single winning move
    start_game(12'h007);
    check_eq("s1_play", state_a, S_PLAY);
    press(0);
    check_eq("s1_board", board_a, 12'h000);
    check_eq("s1_step", step_a, 1);
    release_all();
    check_eq("s1_won", state_a, S_WON);
    check_eq("s1_winflag", win_a, 1);
    check_eq("s1_timer", ten_a, 0);
    $display("txn win board=%h step=%0d state=%0d", board_a, step_a, state_a);

    // Move limit on the MAX_STEPS=3 instance
    start_game(12'h001);
    press(1); check_eq("s2_b1", board_b, 12'h039); release_all();
    press(1); check_eq("s2_b2", board_b, 12'h001); release_all();
    press(1); check_eq("s2_b3", board_b, 12'h039); check_eq("s2_step", step_b, 3);
    release_all();
    check_eq("s2_lost", state_b, S_LOST);
    check_eq("s2_loseflag", lose_b, 1);
    check_eq("s2_a_play", state_a, S_PLAY);
    $display("txn lose board=%h step=%0d state=%0d", board_b, step_b, state_b);

    // Simultaneous edges ignored; held button moves once
    start_game(12'h001);
    act_bt = 4'b0011;
    cycle();
    check_eq("s3_multi_board", board_a, 12'h001);
    check_eq("s3_multi_step", step_a, 0);
    release_all();
    act_bt = 4'b0001;
    repeat (4) cycle();
    check_eq("s3_hold_board", board_a, 12'h006);
    check_eq("s3_hold_step", step_a, 1);
    release_all();
    $display("txn multi/hold board=%h step=%0d", board_a, step_a);

    // Undo
    start_game(12'h001);
    press(2); check_eq("s4_move", board_a, 12'h1C1); release_all();
    undo_bt = 1'b1; cycle(); undo_bt = 1'b0; cycle();
    check_eq("s4_undo1_board", board_a, UNDO_ON ? 12'h001 : 12'h1C1);
    check_eq("s4_undo1_step", step_a, UNDO_ON ? 0 : 1);
    undo_bt = 1'b1; cycle(); undo_bt = 1'b0; cycle();
    check_eq("s4_undo2_board", board_a, UNDO_ON ? 12'h001 : 12'h1C1);
    $display("txn undo board=%h step=%0d", board_a, step_a);

    // LFSR board
    start_sw = 1'b0; cycle();
    random_sw = 1'b1; start_sw = 1'b1; set_bt = 1'b1;
    exp_rand = (m_lfsr[CELLS-1:0] == '0) ? 12'h001 : m_lfsr[CELLS-1:0];
    cycle();
    check_eq("s5_rand_board", board_a, exp_rand);
    check_eq("s5_rand_nz", board_a != '0, 1);
    set_bt = 1'b0; random_sw = 1'b0;
    start_sw = 1'b0; cycle();
    check_eq("s5_sel_state", state_a, S_SELECT);
    check_eq("s5_sel_board", board_a, 0);
    $display("txn random board=%h", exp_rand);

    // Asynchronous reset mid-PLAY
    start_game(12'h800);
    for (int i = 0; i < 5; i++) begin press(i % 2); release_all(); end
    check_eq("s6_step5", step_a, 5);
    check_eq("s6_board", board_a, 12'h807);
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("s6_rst_board", board_a, 0);
    check_eq("s6_rst_step", step_a, 0);
    check_eq("s6_rst_state", state_a, S_SELECT);
    check_eq("s6_rst_flags", {ten_a, win_a, lose_a, ten_b, win_b, lose_b}, 0);
    cycle();
    rst = 1'b1;
    cycle();
    $display("txn reset state=%0d board=%h", state_a, board_a);

    // Randomised play against the model
    for (int n = 0; n < 3000; n++) begin
      start_sw  = ($urandom_range(0, 15) != 0);
      set_bt    = ($urandom_range(0, 3) == 0);
      act_bt    = NBTN'($urandom) & NBTN'($urandom);
      undo_bt   = ($urandom_range(0, 3) == 0);
      random_sw = $urandom_range(0, 1) == 1;
      board_in  = ($urandom_range(0, 3) == 0) ? mask_of($urandom_range(0, 3)) : CELLS'($urandom);
      cycle();
    end
    $display("txn random_run cycles=3000");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
